// File: rtl/muldiv_unit.sv
// Iterative M-extension multiply/divide unit; optional early-out path under MULDIV_EARLY_OUT_EN.
// Latency XLEN+1 cycles from accepting edge to done (1 cycle for early-out cases when enabled).
// No backpressure: start is only sampled in IDLE; busy holds off the pipeline until done.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      aluControl,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [3:0] OP_MUL    = 4'b0110;
  localparam logic [3:0] OP_MULH   = 4'b0111;
  localparam logic [3:0] OP_MULHU  = 4'b1000;
  localparam logic [3:0] OP_MULHSU = 4'b1001;
  localparam logic [3:0] OP_DIV    = 4'b1011;
  localparam logic [3:0] OP_DIVU   = 4'b1100;
  localparam logic [3:0] OP_REM    = 4'b1101;
  localparam logic [3:0] OP_REMU   = 4'b1110;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  typedef struct packed {
    logic mul;   // multiply (else divide)
    logic hi;    // return upper product half
    logic rem;   // return remainder
    logic neg;   // negate magnitude result
    logic dz;    // divisor was zero
  } ctl_t;

  state_t            state;
  ctl_t              ctl;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic              early_q;

  logic            is_m, dec_mul, dec_hi, dec_rem, a_signed, b_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  ctl_t            new_ctl;
  logic            early_hit;
  logic [XLEN-1:0] early_val;

  always_comb begin
    is_m     = 1'b1;
    dec_mul  = 1'b0;
    dec_hi   = 1'b0;
    dec_rem  = 1'b0;
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (aluControl)
      OP_MUL:    begin dec_mul = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
      OP_MULH:   begin dec_mul = 1'b1; dec_hi = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
      OP_MULHU:  begin dec_mul = 1'b1; dec_hi = 1'b1; end
      OP_MULHSU: begin dec_mul = 1'b1; dec_hi = 1'b1; a_signed = 1'b1; end
      OP_DIV:    begin a_signed = 1'b1; b_signed = 1'b1; end
      OP_DIVU:   begin end
      OP_REM:    begin dec_rem = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
      OP_REMU:   begin dec_rem = 1'b1; end
      default:   is_m = 1'b0;
    endcase
    a_neg = a_signed & srcA[XLEN-1];
    b_neg = b_signed & srcB[XLEN-1];
    a_abs = a_neg ? -srcA : srcA;
    b_abs = b_neg ? -srcB : srcB;
    new_ctl.mul = dec_mul;
    new_ctl.hi  = dec_hi;
    new_ctl.rem = dec_rem;
    // Remainder follows the dividend; product and quotient follow the XOR of signs.
    new_ctl.neg = dec_rem ? a_neg : (a_neg ^ b_neg);
    new_ctl.dz  = (srcB == '0);
  end

`ifdef MULDIV_EARLY_OUT_EN
  always_comb begin
    early_hit = 1'b0;
    early_val = '0;
    if (dec_mul) begin
      early_hit = (srcA == '0) || (srcB == '0);
    end else if (srcB == '0) begin
      early_hit = 1'b1;
      early_val = dec_rem ? srcA : '1;
    end else if (a_signed && b_signed && srcA == MIN_VAL && srcB == '1) begin
      early_hit = 1'b1;
      early_val = dec_rem ? '0 : MIN_VAL;
    end
  end
`else
  assign early_hit = 1'b0;
  assign early_val = '0;
`endif

  // One shift-add multiply step: multiplier sits in acc low half, product grows from the top.
  logic [XLEN:0]     msum;
  logic [2*XLEN-1:0] mul_next;
  // One restoring-division step: remainder in acc high half, dividend/quotient in low half.
  logic [XLEN:0]     dtrial;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    msum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {msum, acc[XLEN-1:1]};
    dtrial   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opnd};
    div_next = {dtrial[XLEN] ? acc[2*XLEN-2:XLEN-1] : dtrial[XLEN-1:0],
                acc[XLEN-2:0], ~dtrial[XLEN]};
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_mag, div_fix, fix_val;

  always_comb begin
    prod_fix = ctl.neg ? -acc : acc;
    div_mag  = ctl.rem ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    div_fix  = ctl.neg ? -div_mag : div_mag;
    // Remainder of x/0 falls out as x after sign restore; only the quotient needs forcing.
    if (ctl.dz && !ctl.rem) div_fix = '1;
    if (ctl.mul) fix_val = ctl.hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    else         fix_val = div_fix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cnt     <= '0;
      ctl     <= '0;
      opnd    <= '0;
      acc     <= '0;
      early_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && is_m) begin
            state   <= CALC;
            busy    <= 1'b1;
            ctl     <= new_ctl;
            cnt     <= '0;
            early_q <= early_hit;
            opnd    <= dec_mul ? a_abs : b_abs;
            if (early_hit)    acc <= {{XLEN{1'b0}}, early_val};
            else if (dec_mul) acc <= {{XLEN{1'b0}}, b_abs};
            else              acc <= {{XLEN{1'b0}}, a_abs};
          end
        end
        CALC: begin
          if (early_q) begin
            result <= acc[XLEN-1:0];
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            acc <= ctl.mul ? mul_next : div_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= FIX;
          end
        end
        FIX: begin
          result <= fix_val;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
